// File: rtl/ccff_bitstream_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : ccff_bitstream_loader_if
// Purpose  : Valid/ready word stream that carries the configuration bitstream
//            into the ccff bitstream loader.
// Signals  : bs_data  - bitstream word, bit 0 is shifted first
//            bs_valid - bs_data is valid
//            bs_last  - marks the final word of the bitstream
//            bs_ready - loader accepts a word this cycle
// Modports : master - bitstream source, slave - loader
// Revision : 1.0 - initial release
// ============================================================================
interface ccff_bitstream_loader_if #(
  parameter int WORD_W = 8
);
  logic [WORD_W-1:0] bs_data;
  logic              bs_valid;
  logic              bs_last;
  logic              bs_ready;

  modport master (
    output bs_data,
    output bs_valid,
    output bs_last,
    input  bs_ready
  );

  modport slave (
    input  bs_data,
    input  bs_valid,
    input  bs_last,
    output bs_ready
  );
endinterface
`default_nettype wire

// File: rtl/ccff_bitstream_loader.sv
`default_nettype none
// ============================================================================
// Module   : ccff_bitstream_loader
// Purpose  : Accepts a configuration bitstream as WORD_W-bit words, serialises
//            it onto the head of the ccff chain with a matching shift enable,
//            counts shifted bits and checks bs_last framing.
// Ports    : prog_clk       - configuration clock
//            pReset         - synchronous active-high reset
//            start          - begin a load (honoured in IDLE, DONE, ERR)
//            abort          - cancel an ongoing load, return to IDLE
//            bs             - bitstream word stream (slave side)
//            ccff_head      - serial bit into the chain head
//            chain_shift_en - chain samples ccff_head on this edge
//            busy           - load in progress (FETCH or SHIFT)
//            done           - exactly CHAIN_LEN bits shifted, framing correct
//            err            - 0 none, 1 underrun, 2 overrun
//            bit_count      - bits shifted in the current/last load
// Revision : 1.0 - initial release
// ============================================================================
module ccff_bitstream_loader #(
  parameter int WORD_W    = 8,
  parameter int CHAIN_LEN = 22,
  parameter int CNT_W     = 16
) (
  input  wire logic              prog_clk,
  input  wire logic              pReset,
  input  wire logic              start,
  input  wire logic              abort,
  ccff_bitstream_loader_if.slave bs,
  output logic                   ccff_head,
  output logic                   chain_shift_en,
  output logic                   busy,
  output logic                   done,
  output logic [1:0]             err,
  output logic [CNT_W-1:0]       bit_count
);

  localparam int N_WORDS   = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int LAST_BITS = CHAIN_LEN - (N_WORDS - 1) * WORD_W;

  localparam logic [CNT_W-1:0] c_N_WORDS     = CNT_W'(N_WORDS);
  localparam logic [CNT_W-1:0] c_ONE         = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_WORD_LAST   = CNT_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0] c_FINAL_LAST  = CNT_W'(LAST_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_SHIFT = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t            r_state;
  logic [WORD_W-1:0] r_sreg;
  logic [CNT_W-1:0]  r_words_left;
  logic [CNT_W-1:0]  r_bits_left;   // bits remaining in the word after the one on ccff_head
  logic [CNT_W-1:0]  r_bit_count;
  logic              r_ccff_head;
  logic              r_shift_en;
  logic              r_done;
  logic [1:0]        r_err;

  assign bs.bs_ready     = (r_state == S_FETCH);
  assign busy            = (r_state == S_FETCH) || (r_state == S_SHIFT);
  assign ccff_head       = r_ccff_head;
  assign chain_shift_en  = r_shift_en;
  assign done            = r_done;
  assign err             = r_err;
  assign bit_count       = r_bit_count;

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      r_state      <= S_IDLE;
      r_sreg       <= '0;
      r_words_left <= '0;
      r_bits_left  <= '0;
      r_bit_count  <= '0;
      r_ccff_head  <= 1'b0;
      r_shift_en   <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 2'd0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            r_bit_count  <= '0;
            r_done       <= 1'b0;
            r_err        <= 2'd0;
            r_words_left <= c_N_WORDS;
            r_state      <= S_FETCH;
          end
        end

        S_FETCH: begin
          if (abort) begin
            r_state <= S_IDLE;
          end else if (bs.bs_valid) begin
            if (bs.bs_last && (r_words_left > c_ONE)) begin
              r_err   <= 2'd1;
              r_state <= S_ERR;
            end else if (!bs.bs_last && (r_words_left == c_ONE)) begin
              r_err   <= 2'd2;
              r_state <= S_ERR;
            end else begin
              // Bit 0 goes straight to the head register so it is presented
              // together with the enable in the first SHIFT cycle.
              r_ccff_head  <= bs.bs_data[0];
              r_sreg       <= bs.bs_data >> 1;
              r_shift_en   <= 1'b1;
              r_bits_left  <= (r_words_left == c_ONE) ? c_FINAL_LAST : c_WORD_LAST;
              r_words_left <= r_words_left - c_ONE;
              r_state      <= S_SHIFT;
            end
          end
        end

        S_SHIFT: begin
          if (abort) begin
            r_shift_en <= 1'b0;
            r_state    <= S_IDLE;
          end else begin
            r_bit_count <= r_bit_count + c_ONE;
            if (r_bits_left == '0) begin
              // Last bit of this word is on the head now; drop the enable so
              // the chain holds while the next word is fetched.
              r_shift_en <= 1'b0;
              if (r_words_left == '0) begin
                r_done  <= 1'b1;
                r_state <= S_DONE;
              end else begin
                r_state <= S_FETCH;
              end
            end else begin
              r_ccff_head <= r_sreg[0];
              r_sreg      <= r_sreg >> 1;
              r_bits_left <= r_bits_left - c_ONE;
            end
          end
        end

        default: begin
          r_shift_en <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
